iter_mul_div: RTL and testbench
===============================

# iter_mul_div

Sequential shift-and-add multiplier and restoring divider for the CPU datapath. It is a parametrised successor to the single-cycle multiply/divide unit. Operands are captured on a start handshake, the block iterates one bit per cycle, and it writes a 2N-bit result into internal HI/LO registers while signalling completion. It supports signed and unsigned variants, flags divide-by-zero, and keeps direct HI/LO write ports for move-to-HI/LO instructions.

## Interface
Parameters:
- N, default 16: operand width and HI/LO width. Legal range is N ≥ 2.

Ports:
- clk  in  1  — rising-edge clock.
- rst  in  1  — synchronous reset, active-high.
- start  in  1  — request an operation. Sampled only while idle.
- op  in  2  — operation select: 00 = MULU, 01 = MULS, 10 = DIVU, 11 = DIVS.
- a  in  N  — multiplicand, or dividend.
- b  in  N  — multiplier, or divisor.
- wr_hi  in  1  — write `a` into HI. Effective only while idle.
- wr_lo  in  1  — write `a` into LO. Effective only while idle.
- busy  out  1  — high while an operation is in flight.
- done  out  1  — one-cycle pulse when the result is valid in HI/LO.
- dz  out  1  — divide-by-zero flag. Valid with `done`; holds until the next accepted start.
- hi  out  N  — HI register: product upper half, or remainder.
- lo  out  N  — LO register: product lower half, or quotient.

## Operation
- **States:** IDLE → CALC → FIN → IDLE.
- **IDLE**
  - `start` = 1: latch `op`, `a`, `b`; clear `dz`; load the iteration count to 0; go to CALC.
  - `start` takes priority over `wr_hi`/`wr_lo` in the same cycle; those writes are dropped.
  - Without `start`: `wr_hi` loads HI ← `a` and `wr_lo` loads LO ← `a`. Both may fire together.
- **CALC**
  - Performs one iteration per cycle for N cycles, then moves to FIN.
  - Multiply: unsigned shift-add on operand magnitudes, producing a 2N-bit partial product.
  - Divide: restoring division on magnitudes, producing an N-bit partial remainder and quotient.
- **FIN**
  - Applies sign correction and writes HI/LO.
  - Sets `dz` if the operation was a divide and b == 0.
  - Pulses `done`, then returns to IDLE.
- **Signed rules**
  - MULS: the product is negated when the operand signs differ; the result is the exact 2N-bit two's-complement product.
  - DIVS: the quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Most-negative ÷ −1: LO = most-negative value and HI = 0, via the natural two's-complement wrap. No flag is raised.
- **Divide by zero**
  - Same latency as a normal divide.
  - LO = all ones and HI = the latched `a`, for both DIVU and DIVS.
  - `dz` = 1.
- **Operand isolation:** `a`, `b`, `op`, `start`, `wr_hi` and `wr_lo` are ignored while busy.
- **Reset:** state = IDLE; hi = 0, lo = 0; busy = 0, done = 0, dz = 0.
  - Reset asserted mid-operation aborts the operation: no `done`, and HI/LO are cleared.

## Timing
- Edge E0 samples `start` in IDLE.
- `busy` = 1 from after E0 through E(N+1); busy is simply state ≠ IDLE.
- Edges E1..EN perform the iterations; the state is FIN after EN.
- E(N+1) writes HI/LO and `dz`.
  - `done` = 1 in the cycle following E(N+1), registered.
  - `busy` = 0 in that same cycle.
- Latency from the start edge to valid HI/LO is N+1 cycles; for N = 16 this is 17.
- A new `start` may be presented in the cycle where `done` = 1. It is accepted at that cycle's edge, giving back-to-back throughput of one operation per N+2 cycles.
- `wr_hi`/`wr_lo` update HI/LO at the sampling edge, visible the next cycle.
- The iteration counter is ⌈log2(N+1)⌉ bits wide.

## Test plan (N = 16)
- **MULU:** MULU a = 0xFFFF, b = 0xFFFF → HI = 0xFFFE, LO = 0x0001; `done` exactly 17 cycles after the start edge; `busy` high for 17 cycles.
- **MULS / DIVU:**
  - MULS a = 0xFFFD, b = 0x0005 → HI = 0xFFFF, LO = 0xFFF1.
  - DIVU a = 100, b = 7 → LO = 14, HI = 2, `dz` = 0.
- **DIVS:**
  - DIVS a = 0xFFF9 (−7), b = 0x0002 → LO = 0xFFFD, HI = 0xFFFF.
  - DIVS a = 0x8000, b = 0xFFFF → LO = 0x8000, HI = 0x0000.
- **Divide by zero:** DIVU a = 0x1234, b = 0 → LO = 0xFFFF, HI = 0x1234, `dz` = 1 with `done`. A following MULU start clears `dz`.
- **Busy isolation:**
  - During busy, toggle `a`/`b`, pulse `start`, pulse `wr_hi` → result unaffected, no second operation.
  - In IDLE, `wr_hi` with a = 0x00AB plus `wr_lo` with a = 0x00CD on separate cycles → HI = 0x00AB, LO = 0x00CD.
  - In IDLE, `start` and `wr_lo` together → the write is dropped.
- **Reset mid-operation:** assert `rst` 5 cycles into a MULU → the next cycle shows busy = 0, hi = 0, lo = 0, and `done` never pulses. A fresh start then completes normally.

Source files
------------

// File: rtl/iter_mul_div.sv
// iter_mul_div: iterative multiply/divide unit with HI/LO result registers.
//
// One bit of the operation is processed per clock. A start in idle captures
// the operands; N iteration cycles follow, then one finish cycle applies sign
// correction and writes HI/LO while raising a registered done pulse.
//
// Ports:
//   clk    - rising-edge clock
//   rst    - synchronous active-high reset
//   start  - request an operation (sampled only while idle)
//   op     - 00 MULU, 01 MULS, 10 DIVU, 11 DIVS
//   a, b   - multiplicand/multiplier or dividend/divisor
//   wr_hi  - load HI from a while idle
//   wr_lo  - load LO from a while idle
//   busy   - operation in flight (state is not idle)
//   done   - one-cycle pulse when HI/LO hold a fresh result
//   dz     - divide-by-zero flag, valid with done, held until next start
//   hi, lo - result registers (product high/low, or remainder/quotient)
module iter_mul_div #(
  parameter int unsigned N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         wr_hi,
  input  logic         wr_lo,
  output logic         busy,
  output logic         done,
  output logic         dz,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFin
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           is_div_q, is_div_d;
  logic           sign_a_q, sign_a_d;
  logic           sign_b_q, sign_b_d;
  logic           b_zero_q, b_zero_d;
  logic [N-1:0]   a_raw_q, a_raw_d;
  // Multiplicand magnitude for multiply, divisor magnitude for divide.
  logic [N-1:0]   opnd_q, opnd_d;
  // Multiply: acc = product upper half, shr = multiplier shifting out / lower half.
  // Divide:   acc = partial remainder,  shr = dividend shifting out / quotient.
  logic [N-1:0]   acc_q, acc_d;
  logic [N-1:0]   shr_q, shr_d;
  logic [N-1:0]   hi_q, hi_d;
  logic [N-1:0]   lo_q, lo_d;
  logic           done_q, done_d;
  logic           dz_q, dz_d;

  // Operand magnitudes at capture time.
  logic           in_sign_a, in_sign_b;
  logic [N-1:0]   in_mag_a, in_mag_b;

  // Iteration datapath.
  logic [N:0]     mul_sum;
  logic [N:0]     div_trial;
  logic [N-1:0]   div_diff;
  logic           div_ge;

  // Finish datapath.
  logic [2*N-1:0] prod_mag;
  logic [2*N-1:0] prod_fix;
  logic [N-1:0]   quot_fix;
  logic [N-1:0]   rem_fix;

  always_comb begin
    in_sign_a = op[0] & a[N-1];
    in_sign_b = op[0] & b[N-1];
    in_mag_a  = in_sign_a ? -a : a;
    in_mag_b  = in_sign_b ? -b : b;
  end

  always_comb begin
    mul_sum   = {1'b0, acc_q} + (shr_q[0] ? {1'b0, opnd_q} : '0);
    div_trial = {acc_q, shr_q[N-1]};
    div_ge    = div_trial >= {1'b0, opnd_q};
    // When div_ge holds the difference is below the divisor, so N bits suffice.
    div_diff  = div_trial[N-1:0] - opnd_q;
  end

  always_comb begin
    prod_mag = {acc_q, shr_q};
    prod_fix = (sign_a_q ^ sign_b_q) ? -prod_mag : prod_mag;
    quot_fix = (sign_a_q ^ sign_b_q) ? -shr_q : shr_q;
    rem_fix  = sign_a_q ? -acc_q : acc_q;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    b_zero_d = b_zero_q;
    a_raw_d  = a_raw_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    shr_d    = shr_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dz_d     = dz_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          is_div_d = op[1];
          sign_a_d = in_sign_a;
          sign_b_d = in_sign_b;
          b_zero_d = (b == '0);
          a_raw_d  = a;
          opnd_d   = op[1] ? in_mag_b : in_mag_a;
          acc_d    = '0;
          shr_d    = op[1] ? in_mag_a : in_mag_b;
          cnt_d    = '0;
          dz_d     = 1'b0;
          state_d  = StCalc;
        end else begin
          if (wr_hi) hi_d = a;
          if (wr_lo) lo_d = a;
        end
      end

      StCalc: begin
        if (is_div_q) begin
          acc_d = div_ge ? div_diff : div_trial[N-1:0];
          shr_d = {shr_q[N-2:0], div_ge};
        end else begin
          acc_d = mul_sum[N:1];
          shr_d = {mul_sum[0], shr_q[N-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) state_d = StFin;
      end

      StFin: begin
        if (is_div_q) begin
          if (b_zero_q) begin
            lo_d = '1;
            hi_d = a_raw_q;
            dz_d = 1'b1;
          end else begin
            lo_d = quot_fix;
            hi_d = rem_fix;
          end
        end else begin
          hi_d = prod_fix[2*N-1:N];
          lo_d = prod_fix[N-1:0];
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      b_zero_q <= 1'b0;
      a_raw_q  <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      shr_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      b_zero_q <= b_zero_d;
      a_raw_q  <= a_raw_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      shr_q    <= shr_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  always_comb begin
    busy = (state_q != StIdle);
    done = done_q;
    dz   = dz_q;
    hi   = hi_q;
    lo   = lo_q;
  end

endmodule

// File: tb/tb_iter_mul_div.sv
// Scoreboard bench for iter_mul_div (N = 16): the driver pushes the expected
// HI/LO/dz for each accepted start; a monitor pops and compares on done.
module tb_iter_mul_div;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         wr_hi;
  logic         wr_lo;
  logic         busy;
  logic         done;
  logic         dz;
  logic [N-1:0] hi;
  logic [N-1:0] lo;

  iter_mul_div #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .wr_hi (wr_hi),
    .wr_lo (wr_lo),
    .busy  (busy),
    .done  (done),
    .dz    (dz),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] hi;
    logic [N-1:0] lo;
    logic         dz;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   mon_busy = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model straight from the arithmetic definitions.
  function automatic exp_t model(input logic [1:0] o, input logic [N-1:0] x,
                                 input logic [N-1:0] y);
    exp_t        e;
    int          sx, sy, ux, uy, q, r;
    logic [31:0] p;
    sx = $signed(x);
    sy = $signed(y);
    ux = int'(x);
    uy = int'(y);
    e.dz = 1'b0;
    case (o)
      2'b00: begin p = ux * uy; e.hi = p[31:16]; e.lo = p[15:0]; end
      2'b01: begin p = sx * sy; e.hi = p[31:16]; e.lo = p[15:0]; end
      default: begin
        if (y == 0) begin
          e.lo = '1;
          e.hi = x;
          e.dz = 1'b1;
        end else begin
          if (o == 2'b10) begin q = ux / uy; r = ux % uy; end
          else            begin q = sx / sy; r = sx % sy; end
          p    = q;
          e.lo = p[15:0];
          p    = r;
          e.hi = p[15:0];
        end
      end
    endcase
    return e;
  endfunction

  // Monitor: counts busy cycles per operation and checks results on done.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_busy = 0;
      end else if (done) begin
        check("done_busy_low", {31'd0, busy}, 32'd0);
        check("busy_cycles", mon_busy, N + 1);
        mon_busy = 0;
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got done=1, expected no pending operation");
        end else begin
          e = sb_q.pop_front();
          check("hi", {16'd0, hi}, {16'd0, e.hi});
          check("lo", {16'd0, lo}, {16'd0, e.lo});
          check("dz", {31'd0, dz}, {31'd0, e.dz});
        end
      end else if (busy) begin
        mon_busy++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Waits for idle; while busy, drives junk on every input to prove isolation.
  task automatic wait_idle();
    int k = 0;
    while (busy && k < 100) begin
      a     = N'($urandom);
      b     = N'($urandom);
      op    = 2'($urandom);
      start = 1'($urandom);
      wr_hi = 1'($urandom);
      wr_lo = 1'($urandom);
      tick();
      k++;
    end
    start = 1'b0;
    wr_hi = 1'b0;
    wr_lo = 1'b0;
    if (busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: got busy=1 after %0d cycles, expected idle", k);
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y);
    wait_idle();
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    sb_q.push_back(model(o, x, y));
    tick();
    start = 1'b0;
    check("start_accepted", {31'd0, busy}, 32'd1);
  endtask

  initial begin
    logic [N-1:0] ra, rb;
    logic [1:0]   ro;
    rst   = 1'b1;
    start = 1'b0;
    wr_hi = 1'b0;
    wr_lo = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;
    repeat (3) tick();
    rst = 1'b0;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_dz", {31'd0, dz}, 32'd0);
    check("reset_hi", {16'd0, hi}, 32'd0);
    check("reset_lo", {16'd0, lo}, 32'd0);

    // Directed cases, issued back to back.
    issue(2'b00, 16'hFFFF, 16'hFFFF);
    issue(2'b01, 16'hFFFD, 16'h0005);
    issue(2'b10, 16'd100, 16'd7);
    issue(2'b11, 16'hFFF9, 16'h0002);
    issue(2'b11, 16'h8000, 16'hFFFF);
    issue(2'b10, 16'h1234, 16'h0000);
    issue(2'b00, 16'h0003, 16'h0004);
    check("dz_cleared_by_start", {31'd0, dz}, 32'd0);

    // Direct HI/LO writes in idle, then start plus wr_lo together.
    wait_idle();
    wr_hi = 1'b1;
    a     = 16'h00AB;
    tick();
    wr_hi = 1'b0;
    wr_lo = 1'b1;
    a     = 16'h00CD;
    tick();
    wr_lo = 1'b0;
    check("wr_hi", {16'd0, hi}, 32'h00AB);
    check("wr_lo", {16'd0, lo}, 32'h00CD);
    start = 1'b1;
    wr_lo = 1'b1;
    op    = 2'b00;
    a     = 16'h5555;
    b     = 16'h0002;
    sb_q.push_back(model(2'b00, 16'h5555, 16'h0002));
    tick();
    start = 1'b0;
    wr_lo = 1'b0;
    check("wr_lo_dropped", {16'd0, lo}, 32'h00CD);
    check("hi_held_in_calc", {16'd0, hi}, 32'h00AB);

    // Reset five cycles into a multiply aborts it.
    issue(2'b00, 16'h1234, 16'h5678);
    repeat (4) tick();
    rst = 1'b1;
    sb_q.delete();
    tick();
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_hi", {16'd0, hi}, 32'd0);
    check("abort_lo", {16'd0, lo}, 32'd0);
    repeat (25) tick();
    issue(2'b00, 16'h00FF, 16'h0101);

    // Randomised operations with divisor and sign corner cases mixed in.
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom);
      ra = N'($urandom);
      rb = N'($urandom);
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = '1;
        2: ra = 16'h8000;
        3: begin ra = 16'h8000; rb = '1; end
        default: ;
      endcase
      issue(ro, ra, rb);
    end

    wait_idle();
    tick();
    check("queue_drained", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
